regs_bank_sb: RTL

//  Parametrised register bank for the processor datapath: two read ports, one data write port

---
 rtl/regs_bank_sb_pkg.sv | 23 ++
 rtl/regs_bank_sb_merge.sv | 26 ++
 rtl/regs_bank_sb.sv | 87 ++++++++
 3 files changed

// File: rtl/regs_bank_sb_pkg.sv
// Shared write-mode encodings for the register bank and decode.
package regs_bank_sb_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_FULL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOW  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_HIGH = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LINK = 3'b011;
  localparam logic [MODE_W-1:0] MODE_JAL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_NOP  = 3'b101;

  // True when the mode updates R[rd] (LINK only touches the link register).
  function automatic logic mode_writes_rd(input logic [MODE_W-1:0] m);
    return (m == MODE_FULL) || (m == MODE_LOW) || (m == MODE_HIGH) || (m == MODE_JAL);
  endfunction

  // True when the mode loads pc into the link register.
  function automatic logic mode_writes_link(input logic [MODE_W-1:0] m);
    return (m == MODE_LINK) || (m == MODE_JAL);
  endfunction

endpackage

// File: rtl/regs_bank_sb_merge.sv
// Computes the value a register holds after a data write in the given mode.
module regs_bank_sb_merge
  import regs_bank_sb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] data,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] new_val
);

  localparam int HALF = DATA_W / 2;

  // Half modes keep the untouched half of the current contents.
  always_comb begin
    new_val = old_val;
    case (mode)
      MODE_FULL, MODE_JAL: new_val = data;
      MODE_LOW:            new_val = {old_val[DATA_W-1:HALF], data[HALF-1:0]};
      MODE_HIGH:           new_val = {data[HALF-1:0], old_val[HALF-1:0]};
      default:             new_val = old_val;
    endcase
  end

endmodule

// File: rtl/regs_bank_sb.sv
// Register bank: two combinational read ports with write bypass, one data
// write port, link write from pc, and a pending-load scoreboard driving stall.
module regs_bank_sb
  import regs_bank_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int LINK_REG = 15,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] pc,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_idx,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DEPTH-1:0]  hit_vec;
  logic [DATA_W-1:0] wr_val;
  logic              rd_wr;
  logic              lk_wr;

  // Single merge shared by the write path and both bypassed read ports.
  regs_bank_sb_merge #(.DATA_W(DATA_W)) u_merge (
    .old_val (regs_q[rd]),
    .data    (data),
    .mode    (mode),
    .new_val (wr_val)
  );

  // Next register values and per-register write hits; rd beats the link write on JAL.
  always_comb begin
    rd_wr = mode_writes_rd(mode);
    lk_wr = mode_writes_link(mode);
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k]  = regs_q[k];
      hit_vec[k] = 1'b0;
      if (!((ZERO_REG != 0) && (k == 0))) begin
        if (rd_wr && (rd == ADDR_W'(k))) begin
          regs_d[k]  = wr_val;
          hit_vec[k] = 1'b1;
        end else if (lk_wr && (k == LINK_REG)) begin
          regs_d[k]  = pc;
          hit_vec[k] = 1'b1;
        end
      end
    end
  end

  // Scoreboard: writes clear pending, a reservation in the same cycle wins.
  always_comb begin
    pend_d = pend_q & ~hit_vec;
    if (res_en && !((ZERO_REG != 0) && (res_idx == '0)))
      pend_d[res_idx] = 1'b1;
  end

  // Register storage and pending bits, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      pend_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= regs_d[k];
      pend_q <= pend_d;
    end
  end

  // Reads see the post-edge value; outputs are forced quiet while in reset.
  assign out_a = rst_n ? regs_d[ra] : '0;
  assign out_b = rst_n ? regs_d[rb] : '0;
  assign stall = rst_n & ((pend_q[ra] & ~hit_vec[ra]) | (pend_q[rb] & ~hit_vec[rb]));

endmodule
